// File: rtl/corelet_ctrl_pkg.sv
// Shared types and constants for the corelet controller.
package corelet_ctrl_pkg;

    localparam int unsigned INST_W = 34;
    localparam int unsigned CNT_W  = 8;

    // Bit positions on the corelet instruction bus.
    localparam int unsigned B_L0_WR = 2;
    localparam int unsigned B_L0_RD = 3;
    localparam int unsigned B_IF_RD = 4;
    localparam int unsigned B_IF_WR = 5;
    localparam int unsigned B_OF_RD = 6;
    localparam int unsigned B_ACC   = 33;

    // inst[1:0] encodings.
    localparam logic [1:0] IW_NONE  = 2'b00;
    localparam logic [1:0] IW_KLOAD = 2'b01;
    localparam logic [1:0] IW_EXEC  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_KPUSH,
        S_GAP,
        S_XLOAD,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/corelet_ctrl_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero.
module ctrl_cnt
    import corelet_ctrl_pkg::*;
#(
    parameter int unsigned w = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [w-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [w-1:0] count;

    // Load has priority over decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - w'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet job sequencer: kernel load/push, activation load/execute, OFIFO drain.
module corelet_ctrl
    import corelet_ctrl_pkg::*;
#(
    parameter int unsigned row    = 8,
    parameter int unsigned col    = 8,
    parameter int unsigned depth  = 64,
    parameter int unsigned addr_w = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] w_base,
    input  logic [addr_w-1:0] a_base,
    input  logic [6:0]        num_act,
    input  logic              acc_cfg,
    input  logic              l0_o_full,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              xmem_cen,
    output logic [addr_w-1:0] xmem_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [6:0]       DEPTH_N = 7'(depth);
    localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(depth);

    state_t            state;
    logic [addr_w-1:0] nxt_addr;
    logic [addr_w-1:0] a_base_q;
    logic [6:0]        num_act_q;
    logic              acc_q;
    logic              rd_q;
    logic [CNT_W-1:0]  occ;

    logic              rd_req, push_k, push_x, of_rd;
    logic              vc_load, vc_dec, vc_zero;
    logic              gc_load, gc_dec, gc_zero;
    logic              dc_load, dc_dec, dc_zero;
    logic [CNT_W-1:0]  vc_val, gc_val, dc_val;
    logic              wr_drop, wr_fire, l0_rd, occ_nz;
    logic [INST_W-1:0] inst_d;

    ctrl_cnt #(.w(CNT_W)) u_vec_cnt (
        .clk(clk), .reset(reset), .load(vc_load), .load_val(vc_val), .dec(vc_dec), .zero(vc_zero)
    );
    ctrl_cnt #(.w(CNT_W)) u_gap_cnt (
        .clk(clk), .reset(reset), .load(gc_load), .load_val(gc_val), .dec(gc_dec), .zero(gc_zero)
    );
    ctrl_cnt #(.w(CNT_W)) u_drain_cnt (
        .clk(clk), .reset(reset), .load(dc_load), .load_val(dc_val), .dec(dc_dec), .zero(dc_zero)
    );

    // A read issued last cycle lands in L0 now, unless L0 is full.
    assign occ_nz  = (occ != '0);
    assign wr_drop = rd_q & (l0_o_full | (occ >= OCC_MAX));
    assign wr_fire = rd_q & ~wr_drop;
    assign l0_rd   = push_k | push_x;

    // Per-state action intents and counter control; load cycles run one extra cycle to let the last write land.
    always_comb begin
        rd_req  = 1'b0;
        push_k  = 1'b0;
        push_x  = 1'b0;
        of_rd   = 1'b0;
        vc_load = 1'b0;
        vc_val  = '0;
        vc_dec  = 1'b0;
        gc_load = 1'b0;
        gc_val  = '0;
        gc_dec  = 1'b0;
        dc_load = 1'b0;
        dc_val  = '0;
        dc_dec  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    vc_load = 1'b1;
                    vc_val  = CNT_W'(col);
                    dc_load = 1'b1;
                    dc_val  = CNT_W'(num_act);
                end
            end
            S_KLOAD: begin
                if (!vc_zero) begin
                    rd_req = 1'b1;
                    vc_dec = 1'b1;
                end else begin
                    vc_load = 1'b1;
                    vc_val  = CNT_W'(col - 1);
                end
            end
            S_KPUSH: begin
                push_k = 1'b1;
                if (vc_zero) begin
                    gc_load = 1'b1;
                    gc_val  = CNT_W'(row - 1);
                end else begin
                    vc_dec = 1'b1;
                end
            end
            S_GAP: begin
                if (!gc_zero) begin
                    gc_dec = 1'b1;
                end else if (num_act_q != '0) begin
                    vc_load = 1'b1;
                    vc_val  = CNT_W'(num_act_q);
                end
            end
            S_XLOAD: begin
                if (!vc_zero) begin
                    rd_req = 1'b1;
                    vc_dec = 1'b1;
                end else begin
                    vc_load = 1'b1;
                    vc_val  = CNT_W'(num_act_q - 7'd1);
                end
            end
            S_EXEC: begin
                push_x = 1'b1;
                vc_dec = ~vc_zero;
            end
            S_DRAIN: begin
                if (!dc_zero && ofifo_valid) begin
                    of_rd  = 1'b1;
                    dc_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next instruction word; accumulate follows each OFIFO read by one cycle.
    always_comb begin
        inst_d          = '0;
        inst_d[B_L0_WR] = wr_fire;
        inst_d[B_L0_RD] = l0_rd;
        inst_d[B_OF_RD] = of_rd;
        inst_d[B_ACC]   = acc_q & inst[B_OF_RD];
        if (push_k) begin
            inst_d[1:0] = IW_KLOAD;
        end else if (push_x) begin
            inst_d[1:0] = IW_EXEC;
        end else begin
            inst_d[1:0] = IW_NONE;
        end
    end

    // Sequencer state, job capture and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            inst      <= '0;
            xmem_cen  <= 1'b1;
            xmem_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            nxt_addr  <= '0;
            a_base_q  <= '0;
            num_act_q <= '0;
            acc_q     <= 1'b0;
            rd_q      <= 1'b0;
            occ       <= '0;
        end else begin
            inst     <= inst_d;
            xmem_cen <= ~rd_req;
            rd_q     <= rd_req;
            done     <= 1'b0;
            occ      <= occ + CNT_W'(wr_fire) - CNT_W'(l0_rd & occ_nz);
            if (wr_drop) begin
                err <= 1'b1;
            end
            if (rd_req) begin
                xmem_addr <= nxt_addr;
                nxt_addr  <= nxt_addr + addr_w'(1);
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_base_q  <= a_base;
                        num_act_q <= num_act;
                        acc_q     <= acc_cfg;
                        nxt_addr  <= w_base;
                        busy      <= 1'b1;
                        if (num_act > DEPTH_N) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_KLOAD;
                        end
                    end
                end
                S_KLOAD: if (vc_zero) state <= S_KPUSH;
                S_KPUSH: if (vc_zero) state <= S_GAP;
                S_GAP: begin
                    if (gc_zero) begin
                        if (num_act_q == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            nxt_addr <= a_base_q;
                            state    <= S_XLOAD;
                        end
                    end
                end
                S_XLOAD: if (vc_zero) state <= S_EXEC;
                S_EXEC:  if (vc_zero) state <= S_DRAIN;
                S_DRAIN: begin
                    if (dc_zero) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: full jobs, zero/over-length jobs, drain pattern, reset, L0 full.
module tb_corelet_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] w_base;
    logic [10:0] a_base;
    logic [6:0]  num_act;
    logic        acc_cfg;
    logic        l0_o_full;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        xmem_cen;
    logic [10:0] xmem_addr;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    int n_rd, n_wr, n_pk, n_px, n_of, n_ofbad, n_acc, n_accbad, n_done, n_bad;
    int wr_pre_pk, timeout, busy_at_done, busy_after;
    logic [10:0] addr_log [0:127];

    corelet_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .w_base(w_base), .a_base(a_base),
        .num_act(num_act), .acc_cfg(acc_cfg), .l0_o_full(l0_o_full), .ofifo_valid(ofifo_valid),
        .inst(inst), .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required end before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0; l0_o_full = 1'b0;
        acc_cfg = 1'b0; num_act = '0; w_base = '0; a_base = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Launch one job and record per-cycle activity until done (mode 3 stops at first EXEC read).
    // mode 0: ofifo_valid held 1; 1: 1,0,1,1,0,1 pattern once EXEC ends; 2: L0 full on 2nd act read; 3: stop in EXEC.
    task automatic run_job(input logic [10:0] wb, input logic [10:0] ab, input logic [6:0] na,
                           input logic ac, input int mode);
        logic [5:0] pat;
        int pat_i;
        logic prev_valid, prev_of, pk_seen;
        pat = 6'b101101; pat_i = -1; prev_of = 1'b0; pk_seen = 1'b0;
        n_rd = 0; n_wr = 0; n_pk = 0; n_px = 0; n_of = 0; n_ofbad = 0; n_acc = 0;
        n_accbad = 0; n_done = 0; n_bad = 0; wr_pre_pk = -1; timeout = 1;
        busy_at_done = 0; busy_after = 1;
        @(negedge clk);
        w_base = wb; a_base = ab; num_act = na; acc_cfg = ac; start = 1'b1;
        ofifo_valid = (mode != 1); l0_o_full = 1'b0;
        prev_valid = ofifo_valid;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            start = (cyc == 15);
            if (!xmem_cen) begin
                if (n_rd < 128) addr_log[n_rd] = xmem_addr;
                n_rd++;
            end
            if (inst[2]) n_wr++;
            if (inst[3] && inst[1:0] == 2'b01) begin
                n_pk++;
                if (!pk_seen) begin pk_seen = 1'b1; wr_pre_pk = n_wr; end
            end
            if (inst[3] && inst[1:0] == 2'b10) n_px++;
            if (inst[5:4] != 2'b00 || inst[32:7] != '0 ||
                (inst[3] && (inst[1:0] == 2'b00 || inst[1:0] == 2'b11)) ||
                (!inst[3] && inst[1:0] != 2'b00)) n_bad++;
            if (inst[6]) begin
                n_of++;
                if (mode == 1 && !prev_valid) n_ofbad++;
            end else if (mode == 1 && prev_valid) begin
                n_ofbad++;
            end
            if (inst[33] !== (prev_of & ac)) n_accbad++;
            if (inst[33]) n_acc++;
            prev_of = inst[6];
            if (mode == 3 && n_px != 0) begin
                timeout = 0;
                return;
            end
            if (done) begin
                n_done++;
                busy_at_done = int'(busy);
                timeout = 0;
                @(negedge clk);
                busy_after = int'(busy);
                if (done) n_done++;
                if (inst[33] !== (prev_of & ac)) n_accbad++;
                if (inst[33]) n_acc++;
                return;
            end
            if (mode == 1) begin
                if (pat_i < 0 && n_px == int'(na)) pat_i = 0;
                if (pat_i >= 0 && pat_i < 6) begin
                    ofifo_valid = pat[5 - pat_i];
                    pat_i++;
                end else begin
                    ofifo_valid = 1'b0;
                end
            end
            if (mode == 2) l0_o_full = (!xmem_cen && xmem_addr == ab + 11'd1);
            prev_valid = ofifo_valid;
        end
    endtask

    task automatic check_addrs(input string tag, input logic [10:0] wb, input logic [10:0] ab, input int na);
        int bad;
        bad = 0;
        for (int i = 0; i < 8; i++) if (addr_log[i] != wb + 11'(i)) bad++;
        for (int i = 0; i < na; i++) if (addr_log[8 + i] != ab + 11'(i)) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        int nd;
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0; l0_o_full = 1'b0;
        acc_cfg = 1'b0; num_act = '0; w_base = '0; a_base = '0;
        @(negedge clk);
        check("rst_inst", int'(inst != '0), 0);
        check("rst_cen", int'(xmem_cen), 1);
        check("rst_addr", int'(xmem_addr), 0);
        check("rst_busy_done_err", int'({busy, done, err}), 0);
        reset_dut();

        // Basic job: 8 kernel reads, 8 pushes, 4 activation reads at 8..11, 4 execs, 4 OFIFO reads.
        run_job(11'd0, 11'd8, 7'd4, 1'b0, 0);
        check("t1_timeout", timeout, 0);
        check("t1_reads", n_rd, 12);
        check_addrs("t1_addrs", 11'd0, 11'd8, 4);
        check("t1_l0_wr", n_wr, 12);
        check("t1_wr_before_push", wr_pre_pk, 8);
        check("t1_kpush", n_pk, 8);
        check("t1_exec", n_px, 4);
        check("t1_ofifo_rd", n_of, 4);
        check("t1_acc", n_acc, 0);
        check("t1_inst_fields", n_bad, 0);
        check("t1_done_pulses", n_done, 1);
        check("t1_busy_at_done", busy_at_done, 1);
        check("t1_busy_after", busy_after, 0);
        check("t1_err", int'(err), 0);

        // Zero-length job: kernel phase only, then done.
        reset_dut();
        run_job(11'd0, 11'd8, 7'd0, 1'b0, 0);
        check("t2_timeout", timeout, 0);
        check("t2_reads", n_rd, 8);
        check("t2_kpush", n_pk, 8);
        check("t2_exec", n_px, 0);
        check("t2_ofifo_rd", n_of, 0);
        check("t2_done_pulses", n_done, 1);
        check("t2_err", int'(err), 0);

        // Over-length job: error, no L0 traffic, done pulse.
        reset_dut();
        run_job(11'd0, 11'd8, 7'd65, 1'b0, 0);
        check("t3_timeout", timeout, 0);
        check("t3_l0_wr", n_wr, 0);
        check("t3_l0_rd", n_pk + n_px, 0);
        check("t3_done_pulses", n_done, 1);
        check("t3_err", int'(err), 1);

        // Gapped drain with accumulation.
        reset_dut();
        run_job(11'd16, 11'd32, 7'd4, 1'b1, 1);
        check("t4_timeout", timeout, 0);
        check_addrs("t4_addrs", 11'd16, 11'd32, 4);
        check("t4_ofifo_rd", n_of, 4);
        check("t4_ofifo_pattern", n_ofbad, 0);
        check("t4_acc", n_acc, 4);
        check("t4_acc_timing", n_accbad, 0);
        check("t4_done_pulses", n_done, 1);

        // Reset during EXEC abandons the job; next start runs normally.
        reset_dut();
        run_job(11'd0, 11'd8, 7'd4, 1'b0, 3);
        check("t5_reached_exec", timeout, 0);
        reset = 1'b1;
        #1;
        check("t5_inst_cleared", int'(inst != '0), 0);
        check("t5_busy_cleared", int'(busy), 0);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("t5_no_done", nd, 0);
        reset = 1'b0;
        run_job(11'd0, 11'd8, 7'd4, 1'b0, 0);
        check("t5_rerun_timeout", timeout, 0);
        check("t5_rerun_reads", n_rd, 12);
        check("t5_rerun_exec", n_px, 4);
        check("t5_rerun_done", n_done, 1);
        check("t5_rerun_err", int'(err), 0);

        // L0 full on one activation write: write dropped, sticky error.
        reset_dut();
        run_job(11'd0, 11'd8, 7'd4, 1'b0, 2);
        check("t6_timeout", timeout, 0);
        check("t6_reads", n_rd, 12);
        check("t6_l0_wr", n_wr, 11);
        check("t6_done_pulses", n_done, 1);
        repeat (3) @(negedge clk);
        check("t6_err_sticky", int'(err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
